// File: rtl/m2s_pkg.sv
// Shared types for the Multi2Sim access sequencer: FSM states, access-type codes, request word.
// No logic; pure declarations and one decode helper.
// Backpressure: not applicable.
package m2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] ACC_LOAD  = 2'd1;
    localparam logic [1:0] ACC_STORE = 2'd2;

    // Request word carries M2S_ADDR_W address bits; the sequencer's ADDR_W must not exceed it.
    localparam int M2S_ADDR_W = 8;

    typedef struct packed {
        logic [1:0]            mod;
        logic [1:0]            typ;
        logic [M2S_ADDR_W-1:0] addr;
    } req_t;

    function automatic logic is_valid_type(input logic [1:0] t);
        return (t == ACC_LOAD) || (t == ACC_STORE);
    endfunction

endpackage

// File: rtl/m2s_req_fifo.sv
// Synchronous request FIFO, DEPTH entries, extra pointer bit for full/empty.
// Latency: write visible at head the cycle after push; head read straight from storage flops.
// Backpressure: writes ignored when full, reads ignored when empty.
module m2s_req_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_vld && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_vld && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_vld && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/m2s_access_sequencer.sv
// Sequences buffered memory requests to the Multi2Sim bridge; optional counters under M2S_ACCESS_STATS_EN.
// Latency: request accepted in cycle N is presented on acc_* in cycle N+1 at the earliest.
// Backpressure: req_ready drops when FIFO full or draining; issue limited by MAX_OUTSTANDING.
module m2s_access_sequencer
    import m2s_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int ADDR_W          = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mod,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [1:0]        acc_mod,
    output logic [1:0]        acc_type,
    output logic [ADDR_W-1:0] acc_addr,
    input  logic              done_pulse,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [3:0]        outstanding,
    output logic [1:0]        err
`ifdef M2S_ACCESS_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_completed,
    output logic [31:0]       stat_stall_cycles
`endif
);

    localparam logic [3:0] MAX_Q = 4'(MAX_OUTSTANDING);
    localparam logic [4:0] MAX_W = 5'(MAX_OUTSTANDING);

    state_t     state_q, state_d;
    logic       rdy_en_q;
    logic       drained_q;
    logic       acc_valid_q;
    req_t       acc_q;
    logic [3:0] out_q;
    logic [1:0] err_q;

    req_t       req_in, fifo_head, load_dat;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic       accept, push_ok, drop, issue, done_eff;
    logic       can_load, bypass, load, all_empty, pending;
    logic       flush_done_c;
    logic [4:0] occ;

    assign req_in = '{mod: req_mod, typ: req_type, addr: M2S_ADDR_W'(req_addr)};

    assign accept   = req_valid && req_ready;
    assign push_ok  = accept && is_valid_type(req_type);
    assign drop     = accept && !is_valid_type(req_type);
    assign issue    = acc_valid_q && acc_ready;
    assign done_eff = done_pulse && (out_q != 4'd0);

    // Occupancy counts the held access as if already issued, and credits this cycle's completion.
    assign occ      = {1'b0, out_q} + {4'd0, acc_valid_q} - {4'd0, done_eff};
    assign can_load = (!acc_valid_q || acc_ready) && (occ < MAX_W);

    // With the FIFO empty, an accepted request goes straight into the output register.
    assign fifo_pop  = can_load && !fifo_empty;
    assign bypass    = can_load && fifo_empty && push_ok;
    assign fifo_push = push_ok && !bypass;
    assign load      = fifo_pop || bypass;
    assign load_dat  = fifo_empty ? req_in : fifo_head;

    assign all_empty = fifo_empty && !acc_valid_q && (out_q == 4'd0);
    assign pending   = !fifo_empty || acc_valid_q || push_ok;

    m2s_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (fifo_push),
        .wr_dat (req_in),
        .rd_vld (fifo_pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        flush_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (push_ok) state_d = ISSUE;
            end
            ISSUE: begin
                if ((out_q == MAX_Q) && pending) state_d = STALL;
                else if (all_empty && !push_ok)  state_d = IDLE;
            end
            STALL: begin
                if (done_pulse) state_d = ISSUE;
            end
            DRAIN: begin
                if (all_empty) begin
                    state_d      = IDLE;
                    flush_done_c = !drained_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_req && (state_q != DRAIN)) state_d = DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rdy_en_q    <= 1'b0;
            drained_q   <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_q       <= '0;
            out_q       <= 4'd0;
            err_q       <= 2'b00;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            // Suppresses repeat flush_done pulses while flush_req stays high with no new work.
            if (!flush_req || push_ok) drained_q <= 1'b0;
            else if (flush_done_c)     drained_q <= 1'b1;
            if (load) begin
                acc_valid_q <= 1'b1;
                acc_q       <= load_dat;
            end else if (acc_ready) begin
                acc_valid_q <= 1'b0;
            end
            out_q <= out_q + {3'd0, issue} - {3'd0, done_eff};
            if (done_pulse && (out_q == 4'd0)) err_q[0] <= 1'b1;
            if (drop)                          err_q[1] <= 1'b1;
        end
    end

    assign req_ready   = rdy_en_q && !fifo_full && (state_q != DRAIN);
    assign acc_valid   = acc_valid_q;
    assign acc_mod     = acc_q.mod;
    assign acc_type    = acc_q.typ;
    assign acc_addr    = ADDR_W'(acc_q.addr);
    assign flush_done  = flush_done_c;
    assign outstanding = out_q;
    assign err         = err_q;

`ifdef M2S_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued       <= '0;
            stat_completed    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (issue && (stat_issued != '1))                    stat_issued       <= stat_issued + 32'd1;
            if (done_eff && (stat_completed != '1))              stat_completed    <= stat_completed + 32'd1;
            if ((state_q == STALL) && (stat_stall_cycles != '1)) stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_m2s_access_sequencer.sv
// Directed bench for m2s_access_sequencer: scoreboard of expected accesses plus point checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge or #1 after rising.
module tb_m2s_access_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [1:0] req_mod, req_type;
    logic [7:0] req_addr;
    logic       acc_valid, acc_ready;
    logic [1:0] acc_mod, acc_type;
    logic [7:0] acc_addr;
    logic       done_pulse, flush_req, flush_done;
    logic [3:0] outstanding;
    logic [1:0] err;
`ifdef M2S_ACCESS_STATS_EN
    logic [31:0] stat_issued, stat_completed, stat_stall_cycles;
`endif

    int          tests = 0;
    int          fails = 0;
    int          flush_pulses = 0;
    logic [11:0] exp_q[$];
    logic [11:0] sb_e;

    always #5 clk = ~clk;

    m2s_access_sequencer #(.DEPTH(4), .ADDR_W(8), .MAX_OUTSTANDING(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mod     (req_mod),
        .req_type    (req_type),
        .req_addr    (req_addr),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_mod     (acc_mod),
        .acc_type    (acc_type),
        .acc_addr    (acc_addr),
        .done_pulse  (done_pulse),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .outstanding (outstanding),
        .err         (err)
`ifdef M2S_ACCESS_STATS_EN
        ,
        .stat_issued       (stat_issued),
        .stat_completed    (stat_completed),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds a request until accepted; returns 1 unit after the accepting edge.
    task automatic send(input logic [1:0] m, input logic [1:0] t, input logic [7:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_mod   = m;
        req_type  = t;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: req_ready stayed 0 for 50 cycles, expected 1");
            req_valid = 1'b0;
        end else begin
            if (t == 2'd1 || t == 2'd2) exp_q.push_back({m, t, a});
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor: every bridge handshake must match the oldest expected request.
    always @(negedge clk) begin
        if (rst_n && flush_done) flush_pulses++;
        if (rst_n && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got access 0x%0h, expected none", {acc_mod, acc_type, acc_addr});
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_access", {20'd0, acc_mod, acc_type, acc_addr}, {20'd0, sb_e});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_mod    = 2'd0;
        req_type   = 2'd0;
        req_addr   = 8'd0;
        acc_ready  = 1'b0;
        done_pulse = 1'b0;
        flush_req  = 1'b0;
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        chk("rst_flush_done", flush_done, 0);
        rst_n = 1'b1;
        step(1);
        chk("rst_ready_after_clk", req_ready, 1);

        // Single access, held off by the bridge for 5 cycles
        send(2'd1, 2'd1, 8'h5A);
        chk("t1_acc_valid", acc_valid, 1);
        chk("t1_acc_fields", {acc_mod, acc_type, acc_addr}, 12'h55A);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t3_hold_fields", {acc_valid, acc_mod, acc_type, acc_addr}, 13'h155A);
            chk("t3_hold_out", outstanding, 0);
        end
        acc_ready = 1'b1;
        step(1);
        acc_ready = 1'b0;
        chk("t1_out_after_issue", outstanding, 1);
        chk("t1_vld_after_issue", acc_valid, 0);
        done_pulse = 1'b1;
        step(1);
        done_pulse = 1'b0;
        chk("t1_out_after_done", outstanding, 0);

        // Limit of 4 outstanding, FIFO fills, each completion releases one issue
        acc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(2'(i), (i % 2) ? 2'd2 : 2'd1, 8'h10 + 8'(i));
        end
        chk("t2_full_ready", req_ready, 0);
        chk("t2_out_limit", outstanding, 4);
        chk("t2_no_issue", acc_valid, 0);
        chk("t2_issued_4", exp_q.size(), 4);
        step(2);
        chk("t2_stall_out", outstanding, 4);
        chk("t2_stall_pending", exp_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            done_pulse = 1'b1;
            step(1);
            done_pulse = 1'b0;
            chk("t2_release_vld", acc_valid, 1);
            chk("t2_release_out", outstanding, 3);
            step(1);
            chk("t2_reissue_out", outstanding, 4);
        end
        chk("t2_all_issued", exp_q.size(), 0);

        // Same-cycle issue and completion, then completion underflow
        done_pulse = 1'b1;
        step(2);
        done_pulse = 1'b0;
        chk("t4_out_2", outstanding, 2);
        acc_ready = 1'b0;
        send(2'd2, 2'd2, 8'h77);
        chk("t4_acc_valid", acc_valid, 1);
        acc_ready  = 1'b1;
        done_pulse = 1'b1;
        step(1);
        acc_ready  = 1'b0;
        done_pulse = 1'b0;
        chk("t4_same_cycle_out", outstanding, 2);
        done_pulse = 1'b1;
        step(2);
        done_pulse = 1'b0;
        chk("t4_out_0", outstanding, 0);
        chk("t4_err_clear", err, 0);
        done_pulse = 1'b1;
        step(1);
        done_pulse = 1'b0;
        chk("t4_underflow_err", err, 2'b01);
        chk("t4_underflow_out", outstanding, 0);
        step(3);
        chk("t4_err_sticky", err, 2'b01);

        // Drain with 3 queued and 1 outstanding
        send(2'd0, 2'd1, 8'hA0);
        send(2'd1, 2'd2, 8'hA1);
        send(2'd2, 2'd1, 8'hA2);
        send(2'd3, 2'd2, 8'hA3);
        acc_ready = 1'b1;
        step(1);
        acc_ready = 1'b0;
        chk("t5_out_1", outstanding, 1);
        flush_req = 1'b1;
        step(1);
        chk("t5_drain_ready", req_ready, 0);
        acc_ready = 1'b1;
        step(3);
        acc_ready = 1'b0;
        chk("t5_out_4", outstanding, 4);
        chk("t5_all_issued", exp_q.size(), 0);
        for (int k = 0; k < 3; k++) begin
            done_pulse = 1'b1;
            step(1);
            done_pulse = 1'b0;
            chk("t5_no_early_flush_done", flush_done, 0);
        end
        done_pulse = 1'b1;
        step(1);
        done_pulse = 1'b0;
        chk("t5_flush_done", flush_done, 1);
        chk("t5_ready_still_0", req_ready, 0);
        flush_req = 1'b0;
        step(1);
        chk("t5_flush_done_clear", flush_done, 0);
        chk("t5_ready_back", req_ready, 1);
        chk("t5_one_pulse", flush_pulses, 1);

        // Reset in the middle of a stall, then a reserved-type request
        acc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(2'(i), 2'd1, 8'hB0 + 8'(i));
        end
        step(2);
        chk("t6_stall_out", outstanding, 4);
        chk("t6_stall_queued", exp_q.size(), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_acc_valid", acc_valid, 0);
        chk("t6_rst_fields", {acc_mod, acc_type, acc_addr}, 0);
        chk("t6_rst_out", outstanding, 0);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_flush_done", flush_done, 0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        step(1);
        chk("t6_ready_after_rst", req_ready, 1);
        step(3);
        chk("t6_fifo_empty_vld", acc_valid, 0);
        chk("t6_fifo_empty_out", outstanding, 0);
        send(2'd0, 2'd0, 8'h33);
        chk("t6_reserved_err", err, 2'b10);
        step(2);
        chk("t6_reserved_dropped", acc_valid, 0);
        send(2'd3, 2'd2, 8'hC3);
        chk("t6_after_vld", {acc_valid, acc_mod, acc_type, acc_addr}, 13'h1EC3);
        step(1);
        chk("t6_after_out", outstanding, 1);
        done_pulse = 1'b1;
        step(1);
        done_pulse = 1'b0;
        chk("t6_final_out", outstanding, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
